// File: rtl/reg_sequencer.sv
// Four-cycle instruction sequencer in front of the 16 x 8 register file.
// Drives read selects, runs a small ALU and owns the always-writing file port.
//
// state | meaning
// IDLE  | ready for an instruction, write port refreshes A_sel
// READ  | A_sel/B_sel hold ra/rb while the file output settles
// EXEC  | capture A_in/B_in into the operand registers
// WB    | write rd (writing opcodes), update flags, pulse done/err
module reg_sequencer #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [SEL_W-1:0]  A_sel,
    output logic [SEL_W-1:0]  B_sel,
    input  logic [DATA_W-1:0] A_in,
    input  logic [DATA_W-1:0] B_in,
    output logic [SEL_W-1:0]  replaceSel,
    output logic [DATA_W-1:0] replaceData,
    output logic              zero,
    output logic              carry,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic [15:0]        instr_q, instr_d;
    logic [SEL_W-1:0]   a_sel_q, a_sel_d;
    logic [SEL_W-1:0]   b_sel_q, b_sel_d;
    logic [DATA_W-1:0]  opa_q, opa_d;
    logic [DATA_W-1:0]  opb_q, opb_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [3:0]         opcode;
    logic               illegal;
    logic [DATA_W:0]    sum;
    logic [DATA_W:0]    diff;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_c;
    logic               alu_wr;
    logic               wb_write;

    assign opcode  = instr_q[15:12];
    assign illegal = (opcode >= 4'd10);

    // ALU works from the captured operands, so rd == ra/rb sees pre-write values.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        sum     = {1'b0, opa_q} + {1'b0, opb_q};
        diff    = {1'b0, opa_q} - {1'b0, opb_q};
        case (opcode)
            OP_NOP: alu_wr = 1'b0;
            OP_LDI: alu_res = DATA_W'(instr_q[7:0]);
            OP_ADD: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            OP_SUB: begin
                alu_res = diff[DATA_W-1:0];
                alu_c   = diff[DATA_W];
            end
            OP_AND: alu_res = opa_q & opb_q;
            OP_OR:  alu_res = opa_q | opb_q;
            OP_XOR: alu_res = opa_q ^ opb_q;
            OP_MOV: alu_res = opa_q;
            OP_SHL: begin
                alu_res = {opa_q[DATA_W-2:0], 1'b0};
                alu_c   = opa_q[DATA_W-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, opa_q[DATA_W-1:1]};
                alu_c   = opa_q[0];
            end
            default: alu_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        instr_d = instr_q;
        a_sel_d = a_sel_q;
        b_sel_d = b_sel_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    a_sel_d = SEL_W'(instr[7:4]);
                    b_sel_d = SEL_W'(instr[3:0]);
                    ready_d = 1'b0;
                    state_d = READ;
                end
            end
            READ: state_d = EXEC;
            EXEC: begin
                opa_d   = A_in;
                opb_d   = B_in;
                done_d  = 1'b1;
                err_d   = illegal;
                state_d = WB;
            end
            WB: begin
                if (alu_wr) begin
                    zero_d  = (alu_res == '0);
                    carry_d = alu_c;
                end
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            instr_q <= '0;
            a_sel_q <= '0;
            b_sel_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            instr_q <= instr_d;
            a_sel_q <= a_sel_d;
            b_sel_q <= b_sel_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outside a writing WB the file rewrites A_sel with its own value.
    assign wb_write    = (state_q == WB) && alu_wr;
    assign replaceSel  = wb_write ? SEL_W'(instr_q[11:8]) : a_sel_q;
    assign replaceData = wb_write ? alu_res : A_in;

    assign instr_ready = ready_q;
    assign A_sel       = a_sel_q;
    assign B_sel       = b_sel_q;
    assign zero        = zero_q;
    assign carry       = carry_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: doc/reg_sequencer.md
Name: reg_sequencer

Overview:
- Multi-cycle instruction sequencer that sits directly upstream of the 16 x 8-bit register file.
- Accepts one 16-bit instruction per handshake and drives the file's read selects.
- Captures the returned A/B operands and computes the result in a small internal ALU.
- Drives the file's write port. The file writes on every clock, so this block must keep the write port benign in all non-writeback cycles.

Parameters:
- DATA_W, 8, operand/register width (must match register file).
- SEL_W, 4, register select width (16 registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  16  instruction; [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb; imm8 = [7:0].
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  sequencer can accept an instruction.
- A_sel  output  SEL_W  register file read select A.
- B_sel  output  SEL_W  register file read select B.
- A_in  input  DATA_W  register file output A.
- B_in  input  DATA_W  register file output B.
- replaceSel  output  SEL_W  register file write select.
- replaceData  output  DATA_W  register file write data.
- zero  output  1  registered zero flag.
- carry  output  1  registered carry/borrow flag.
- done  output  1  one-cycle pulse when an instruction retires.
- err  output  1  one-cycle pulse when an illegal opcode retires.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE; A_sel=0, B_sel=0; zero=0, carry=0, done=0, err=0.
  - Instruction and operand registers cleared.
  - instr_ready=1 (IDLE), but nothing is accepted while rst=1.
- Reset mid-operation: in-flight instruction is dropped with no write; flags return to 0.
- Write-port rule (all cycles except a writing WB):
  - replaceSel = A_sel and replaceData = A_in (refresh), so the unconditional file write rewrites an unchanged value.
  - In WB of a writing opcode: replaceSel = rd and replaceData = result register.
- State machine (4 cycles per instruction, no pipelining):
  - IDLE: instr_ready=1. On instr_valid & instr_ready at a rising edge, latch instr -> READ. Otherwise stay in IDLE.
  - READ: instr_ready=0; A_sel=ra, B_sel=rb (registered, held through WB) -> EXEC.
  - EXEC: latch A_in, B_in into operand registers; compute result and next flags into registers -> WB.
  - WB: perform the write if the opcode writes; update zero/carry; done=1; err=1 if illegal -> IDLE.
- Back-to-back: instruction N+1 can be accepted the cycle after N's WB. Minimum spacing between acceptances is 4 cycles.
- instr_valid outside IDLE is ignored; the upstream must hold instr until accepted.
- Opcodes (result width 8, modulo 256):
  - 0 NOP: no write, flags unchanged.
  - 1 LDI: rd=imm8.
  - 2 ADD: rd=a+b, carry = bit 8 of the 9-bit sum.
  - 3 SUB: rd=a-b, carry = borrow (a<b unsigned).
  - 4 AND, 5 OR, 6 XOR: carry=0.
  - 7 MOV: rd=a, carry=0.
  - 8 SHL: rd=a<<1, carry=a msb.
  - 9 SHR: rd=a>>1 logical, carry=a lsb.
  - 10-15 illegal: no write, flags unchanged, err=1 with done=1.
- Flags for writing ops: zero = (result==0). LDI sets carry=0.
- Hazards: rd may equal ra or rb. Operands are captured in EXEC, before the WB write, so the old values are used.
- R0 is an ordinary writable register; no special casing.

Test Plan:
- Reset, then LDI r3,0x5A (0x135A) -> done at 4th cycle after acceptance. replaceSel=3, replaceData=0x5A in WB only; r3 reads 0x5A; zero=0, carry=0.
- r1=0xF0, r2=0x20; ADD r4,r1,r2 (0x2412) -> r4=0x10, carry=1, zero=0. SUB r5,r2,r1 -> r5=0x30, carry=1.
- r6=0x0F; XOR r6,r6,r6 (0x6666) -> r6=0x00, zero=1, carry=0. Bench checks that no other register changes across the whole sequence (refresh correctness).
- Opcode 0xC (0xC123) -> err and done pulse together; no register changes; zero/carry retain prior values.
- instr_valid held high with 3 instructions queued -> accepted at cycles 0, 4, 8; instr_ready low in READ/EXEC/WB.
- Assert rst asynchronously during EXEC of ADD r7,... -> outputs reset immediately; r7 is not written; next instruction executes normally.
